// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the Fibonacci LFSR generator: it locks onto the word stream,
// then flags and counts words that break the sequence, freewheeling over isolated errors.
module lfsr_sequence_checker #(
    parameter int BITS       = 5,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [BITS-1:0]      data,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_WIDTH-1:0] err_count
);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic { SEARCH = 1'b0, LOCKED = 1'b1 } state_t;

    state_t                state, state_n;
    logic [RUN_W-1:0]      run, run_n;
    logic [MISS_W-1:0]     miss, miss_n;
    logic [BITS-1:0]       last, last_n;
    logic                  has_last, has_last_n;
    logic                  error_n;
    logic [ERR_WIDTH-1:0]  err_count_n;
    logic [BITS-1:0]       expect_word;

    // BITS single advances of the generator, i.e. the word that follows w.
    function automatic logic [BITS-1:0] step(input logic [BITS-1:0] w);
        logic [BITS-1:0] d;
        d = w;
        for (int i = 0; i < BITS; i++) begin
            d = {d[BITS-1] ^ d[1], d[BITS-1:1]};
        end
        return d;
    endfunction

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign expect_word = step(last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            run       <= '0;
            miss      <= '0;
            last      <= '0;
            has_last  <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            miss      <= miss_n;
            last      <= last_n;
            has_last  <= has_last_n;
            error     <= error_n;
            err_count <= err_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        run_n       = run;
        miss_n      = miss;
        last_n      = last;
        has_last_n  = has_last;
        error_n     = 1'b0;
        err_count_n = err_count;

        if (valid) begin
            case (state)
                SEARCH: begin
                    if (has_last && (data == expect_word) && (data != '0)) begin
                        run_n = run + 1'b1;
                    end else begin
                        run_n = '0;
                    end
                    last_n     = data;
                    has_last_n = (data != '0);
                    if (run_n == RUN_W'(LOCK_COUNT)) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                        run_n   = '0;
                    end
                end
                LOCKED: begin
                    if (data == expect_word) begin
                        miss_n = '0;
                        last_n = data;
                    end else begin
                        // Freewheel on the prediction so a lone bad word keeps sync.
                        error_n     = 1'b1;
                        err_count_n = sat_inc(err_count);
                        miss_n      = miss + 1'b1;
                        last_n      = expect_word;
                        if (miss_n == MISS_W'(LOSS_COUNT)) begin
                            state_n    = SEARCH;
                            run_n      = '0;
                            miss_n     = '0;
                            last_n     = data;
                            has_last_n = (data != '0);
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        if (clear) begin
            err_count_n = '0;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Scoreboard bench for lfsr_sequence_checker: directed scenarios plus random traffic,
// checked against a word-level model on two instances (16-bit and 2-bit error counters).
module tb_lfsr_sequence_checker;
    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic        clk = 1'b0;
    logic        rst_n, clear, valid;
    logic [4:0]  data;
    logic        locked_a, error_a, locked_b, error_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    lfsr_sequence_checker #(.BITS(5), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
        .locked(locked_a), .error(error_a), .err_count(cnt_a));

    lfsr_sequence_checker #(.BITS(5), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
        .locked(locked_b), .error(error_b), .err_count(cnt_b));

    typedef struct packed {
        logic        lk;
        logic        er;
        logic [15:0] ca;
        logic [1:0]  cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, in plain integers.
    int   succ[32];
    bit   m_locked, m_has, m_err;
    int   m_run, m_miss, m_last, m_ca, m_cb;
    int   gen;

    function automatic int adv1(input int w);
        return (w >> 1) | ((((w >> 4) ^ (w >> 1)) & 1) << 4);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_has = 0; m_err = 0;
        m_run = 0; m_miss = 0; m_last = 0; m_ca = 0; m_cb = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit clr);
        int e;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (m_has && d == succ[m_last] && d != 0) m_run = m_run + 1;
                else m_run = 0;
                m_last = d;
                m_has  = (d != 0);
                if (m_run == LOCK) begin
                    m_locked = 1; m_miss = 0; m_run = 0;
                end
            end else begin
                e = succ[m_last];
                if (d == e) begin
                    m_miss = 0; m_last = d;
                end else begin
                    m_err  = 1;
                    m_ca   = (m_ca < 65535) ? m_ca + 1 : m_ca;
                    m_cb   = (m_cb < 3) ? m_cb + 1 : m_cb;
                    m_miss = m_miss + 1;
                    m_last = e;
                    if (m_miss == LOSS) begin
                        m_locked = 0; m_run = 0; m_miss = 0;
                        m_last = d; m_has = (d != 0);
                    end
                end
            end
        end
        if (clr) begin
            m_ca = 0; m_cb = 0;
        end
    endtask

    task automatic push_exp();
        exp_t x;
        x.lk = m_locked; x.er = m_err; x.ca = 16'(m_ca); x.cb = 2'(m_cb);
        sb.push_back(x);
    endtask

    task automatic cycle(input bit v, input int d, input bit clr);
        @(negedge clk);
        rst_n = 1'b1;
        valid = v;
        data  = 5'(d);
        clear = clr;
        model_step(v, d & 31, clr);
        push_exp();
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'($urandom);
        data  = 5'($urandom);
        clear = 1'($urandom);
        model_reset();
        push_exp();
    endtask

    task automatic send_good(input bit clr);
        cycle(1'b1, gen, clr);
        gen = succ[gen];
    endtask

    task automatic send_bad(input int mask, input bit clr);
        cycle(1'b1, gen ^ mask, clr);
        gen = succ[gen];
    endtask

    task automatic idle(input bit clr);
        cycle(1'b0, int'($urandom_range(0, 31)), clr);
    endtask

    // Monitor: every cycle the DUTs present their registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({locked_a, error_a, cnt_a} !== {e.lk, e.er, e.ca}) begin
                    failures++;
                    $display("FAIL out16 t=%0t got locked=%b error=%b cnt=%0d want locked=%b error=%b cnt=%0d",
                             $time, locked_a, error_a, cnt_a, e.lk, e.er, e.ca);
                end
                checks++;
                if ({locked_b, error_b, cnt_b} !== {e.lk, e.er, e.cb}) begin
                    failures++;
                    $display("FAIL out2 t=%0t got locked=%b error=%b cnt=%0d want locked=%b error=%b cnt=%0d",
                             $time, locked_b, error_b, cnt_b, e.lk, e.er, e.cb);
                end
            end
        end
    end

    initial begin
        int r;
        for (int w = 0; w < 32; w++) begin
            int x;
            x = w;
            for (int k = 0; k < 5; k++) x = adv1(x);
            succ[w] = x;
        end
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; data = '0;
        model_reset();

        // Reset with arbitrary inputs.
        repeat (3) reset_cycle();

        // Acquire, valid every cycle.
        gen = 31;
        repeat (8) send_good(1'b0);

        // Single error, then the stream carries on.
        send_bad(1, 1'b0);
        repeat (3) send_good(1'b0);

        // Loss and relock.
        repeat (3) send_bad(int'($urandom_range(1, 31)), 1'b0);
        repeat (7) send_good(1'b0);

        // Asynchronous reset while locked, checked before the next edge.
        @(negedge clk);
        valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (locked_a !== 1'b0 || error_a !== 1'b0 || cnt_a !== 16'd0 || locked_b !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got locked=%b error=%b cnt=%0d want locked=0 error=0 cnt=0",
                     locked_a, error_a, cnt_a);
        end
        model_reset();
        push_exp();
        reset_cycle();

        // Acquire with gaps in valid.
        gen = 31;
        repeat (7) begin
            send_good(1'b0);
            repeat ($urandom_range(0, 2)) idle(1'b0);
        end

        // Zero in SEARCH after three matches restarts the run.
        reset_cycle();
        gen = 31;
        repeat (4) send_good(1'b0);
        cycle(1'b1, 0, 1'b0);
        gen = succ[gen];
        repeat (6) send_good(1'b0);

        // Saturation of the small counter with alternating errors.
        repeat (5) begin
            send_bad(int'($urandom_range(1, 31)), 1'b0);
            send_good(1'b0);
        end

        // Clear colliding with an accepted mismatch, then clear alone.
        send_bad(2, 1'b1);
        send_good(1'b0);
        send_bad(4, 1'b0);
        send_good(1'b0);
        idle(1'b1);
        send_good(1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20)      idle(1'(r < 2));
            else if (r < 30) send_bad(int'($urandom_range(1, 31)), 1'b0);
            else if (r < 33) begin cycle(1'b1, 0, 1'b0); gen = succ[gen]; end
            else if (r < 36) send_good(1'b1);
            else if (r < 38) begin gen = int'($urandom_range(1, 31)); send_good(1'b0); end
            else if (r < 39) reset_cycle();
            else             send_good(1'b0);
        end

        idle(1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
